oversampled_bit_decider: RTL and testbench

//  Sequential, multi-channel successor to the two-input count comparator. Counts ones per channel

---
 rtl/oversampled_bit_decider.sv | 117 +++++++++++
 tb/tb_oversampled_bit_decider.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/oversampled_bit_decider.sv
// Multi-channel oversampled bit decider: counts ones per lane over a window of SAMPLES*OSF
// accepted samples and registers a majority / threshold / hysteresis decision at window end.
module oversampled_bit_decider #(
  parameter int SAMPLES   = 2,
  parameter int OSF       = 8,
  parameter int CHANNELS  = 1,
  parameter bit TIE_VALUE = 1'b0,
  localparam int W        = SAMPLES * OSF,
  localparam int CW       = $clog2(SAMPLES * OSF) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   SampleValid,
  input  logic [CHANNELS-1:0]    SampleIn,
  input  logic                   Sync,
  input  logic [1:0]             Mode,
  input  logic [CW-1:0]          Threshold,
  input  logic [CW-1:0]          Hyst,
  output logic [CHANNELS-1:0]    DataOut,
  output logic                   DataValid,
  output logic [CHANNELS*CW-1:0] CountOut
);

  localparam logic [CW-1:0] LAST_IDX  = CW'(W - 1);
  localparam logic [CW-1:0] ONE_IDX   = CW'(1);
  localparam logic [CW:0]   W_WIDE    = (CW + 1)'(W);

  logic [CW-1:0]       idx_r;
  logic [CW-1:0]       cnt_r   [CHANNELS];
  logic [CW-1:0]       ones_s  [CHANNELS];
  logic [CHANNELS-1:0] decided_s;
  logic                win_end_s;

  // All comparisons run in CW+1 bits so Threshold+Hyst and 2*ones cannot wrap.
  function automatic logic decide(input logic [1:0]    mode,
                                  input logic [CW-1:0] ones,
                                  input logic [CW-1:0] thr,
                                  input logic [CW-1:0] hyst,
                                  input logic          cur);
    logic [CW:0] ones_w;
    logic [CW:0] twice_w;
    logic [CW:0] band_hi;
    logic [CW:0] band_lo;
    logic        result;
    ones_w  = {1'b0, ones};
    twice_w = {ones, 1'b0};
    band_hi = {1'b0, thr} + {1'b0, hyst};
    band_lo = (thr > hyst) ? ({1'b0, thr} - {1'b0, hyst}) : {(CW + 1){1'b0}};
    case (mode)
      2'b01: result = (ones_w >= {1'b0, thr});
      2'b10: begin
        if (cur) begin
          result = !(ones_w < band_lo);
        end else begin
          result = (ones_w >= band_hi);
        end
      end
      default: begin
        if (twice_w > W_WIDE) begin
          result = 1'b1;
        end else if (twice_w < W_WIDE) begin
          result = 1'b0;
        end else begin
          result = TIE_VALUE;
        end
      end
    endcase
    return result;
  endfunction

  // Running count including the sample presented this cycle, and the decision it would yield.
  always_comb begin
    ones_s    = '{default: {CW{1'b0}}};
    decided_s = {CHANNELS{1'b0}};
    win_end_s = SampleValid && (idx_r == LAST_IDX);
    for (int c = 0; c < CHANNELS; c++) begin
      ones_s[c]    = cnt_r[c] + CW'(SampleIn[c]);
      decided_s[c] = decide(Mode, ones_s[c], Threshold, Hyst, DataOut[c]);
    end
  end

  // Window timing, per-lane counters and registered decision outputs; rst > Sync > window end.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r     <= {CW{1'b0}};
      DataOut   <= {CHANNELS{1'b0}};
      DataValid <= 1'b0;
      CountOut  <= {(CHANNELS * CW){1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_r[c] <= {CW{1'b0}};
      end
    end else if (Sync) begin
      idx_r     <= SampleValid ? ONE_IDX : {CW{1'b0}};
      DataValid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_r[c] <= SampleValid ? CW'(SampleIn[c]) : {CW{1'b0}};
      end
    end else if (win_end_s) begin
      idx_r     <= {CW{1'b0}};
      DataOut   <= decided_s;
      DataValid <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_r[c]              <= {CW{1'b0}};
        CountOut[c*CW +: CW]  <= ones_s[c];
      end
    end else if (SampleValid) begin
      idx_r     <= idx_r + ONE_IDX;
      DataValid <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt_r[c] <= ones_s[c];
      end
    end else begin
      DataValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_oversampled_bit_decider.sv
// Bench for oversampled_bit_decider (2 lanes, W=16): window-level vector table, hand-written
// reset/Sync/throttling sequences, and randomized traffic against a queue-based reference model.
module tb_oversampled_bit_decider;

  localparam int W   = 16;
  localparam int CW  = 5;
  localparam bit TIE = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          SampleValid = 1'b0;
  logic [1:0]    SampleIn = 2'b00;
  logic          Sync = 1'b0;
  logic [1:0]    Mode = 2'b00;
  logic [CW-1:0] Threshold = 5'd0;
  logic [CW-1:0] Hyst = 5'd0;
  logic [1:0]    DataOut;
  logic          DataValid;
  logic [2*CW-1:0] CountOut;

  oversampled_bit_decider #(.SAMPLES(2), .OSF(8), .CHANNELS(2), .TIE_VALUE(TIE)) dut (
    .clk(clk), .rst(rst), .SampleValid(SampleValid), .SampleIn(SampleIn), .Sync(Sync),
    .Mode(Mode), .Threshold(Threshold), .Hyst(Hyst),
    .DataOut(DataOut), .DataValid(DataValid), .CountOut(CountOut)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pulses[$];

  // Reference model: the accepted samples of the open window, and the expected outputs.
  logic [1:0]      win_q[$];
  logic [1:0]      exp_d = 2'b00;
  logic [2*CW-1:0] exp_c = '0;
  logic            exp_v = 1'b0;

  typedef struct {
    logic [1:0] mode;
    int         thr;
    int         hyst;
    int         o0;
    int         o1;
    logic [1:0] exp_d;
  } vec_t;

  vec_t vecs[16];

  function automatic bit ref_decide(int mode, int ones, int thr, int hyst, bit cur);
    int lo;
    case (mode)
      1: return ones >= thr;
      2: begin
        if (!cur) return ones >= thr + hyst;
        lo = thr - hyst;
        if (lo < 0) lo = 0;
        return !(ones < lo);
      end
      default: begin
        if (ones > W - ones) return 1'b1;
        if (ones < W - ones) return 1'b0;
        return TIE;
      end
    endcase
  endfunction

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(bit v, logic [1:0] si, bit sy, bit r);
    int o0, o1;
    logic [1:0] nd;
    if (r) begin
      win_q.delete();
      exp_d = 2'b00;
      exp_c = '0;
      exp_v = 1'b0;
    end else begin
      exp_v = 1'b0;
      if (sy) begin
        win_q.delete();
        if (v) win_q.push_back(si);
      end else if (v) begin
        win_q.push_back(si);
        if (win_q.size() == W) begin
          o0 = 0;
          o1 = 0;
          foreach (win_q[k]) begin
            o0 += int'(win_q[k][0]);
            o1 += int'(win_q[k][1]);
          end
          nd[0] = ref_decide(int'(Mode), o0, int'(Threshold), int'(Hyst), exp_d[0]);
          nd[1] = ref_decide(int'(Mode), o1, int'(Threshold), int'(Hyst), exp_d[1]);
          exp_d = nd;
          exp_c = {5'(o1), 5'(o0)};
          exp_v = 1'b1;
          win_q.delete();
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic step(bit v, logic [1:0] si, bit sy, bit r);
    SampleValid = v;
    SampleIn    = si;
    Sync        = sy;
    rst         = r;
    @(posedge clk);
    model_edge(v, si, sy, r);
    #1;
    cyc++;
    tests++;
    if (DataValid !== exp_v || DataOut !== exp_d || CountOut !== exp_c) begin
      fails++;
      $display("FAIL model cycle %0d: valid/data/count got %b/%b/%h, expected %b/%b/%h",
               cyc, DataValid, DataOut, CountOut, exp_v, exp_d, exp_c);
    end
    if (DataValid === 1'b1) pulses.push_back(cyc);
  endtask

  task automatic send_win(int o0, int o1, bit gap);
    for (int i = 0; i < W; i++) begin
      step(1'b1, {(i < o1), (i < o0)}, 1'b0, 1'b0);
      if (gap) step(1'b0, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    end
  endtask

  initial begin
    vecs[0]  = '{2'b00,  0, 0, 12,  4, 2'b01};
    vecs[1]  = '{2'b00,  0, 0,  3, 13, 2'b10};
    vecs[2]  = '{2'b00,  0, 0,  8,  8, 2'b00};
    vecs[3]  = '{2'b01, 10, 0, 10,  6, 2'b01};
    vecs[4]  = '{2'b01, 10, 0,  9,  7, 2'b00};
    vecs[5]  = '{2'b01, 17, 0, 16,  0, 2'b00};
    vecs[6]  = '{2'b10,  8, 2,  9,  7, 2'b00};
    vecs[7]  = '{2'b10,  8, 2, 10,  6, 2'b01};
    vecs[8]  = '{2'b10,  8, 2,  7,  9, 2'b01};
    vecs[9]  = '{2'b10,  8, 2,  6, 10, 2'b11};
    vecs[10] = '{2'b10,  8, 2,  5, 11, 2'b10};
    vecs[11] = '{2'b01,  0, 0,  0, 16, 2'b11};
    vecs[12] = '{2'b10,  1, 3,  0, 16, 2'b11};
    vecs[13] = '{2'b01, 17, 0, 16,  0, 2'b00};
    vecs[14] = '{2'b10, 15, 3, 16,  0, 2'b00};
    vecs[15] = '{2'b11,  0, 0,  9,  7, 2'b01};

    step(1'b0, 2'b00, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b1);
    check("reset DataOut", DataOut, 0);
    check("reset DataValid", DataValid, 0);
    check("reset CountOut", CountOut, 0);

    // Back-to-back windows, one per table entry.
    for (int n = 0; n < 16; n++) begin
      Mode      = vecs[n].mode;
      Threshold = 5'(vecs[n].thr);
      Hyst      = 5'(vecs[n].hyst);
      pulses.delete();
      send_win(vecs[n].o0, vecs[n].o1, 1'b0);
      check($sformatf("vec%0d pulses", n), pulses.size(), 1);
      check($sformatf("vec%0d DataValid", n), DataValid, 1);
      check($sformatf("vec%0d DataOut", n), DataOut, vecs[n].exp_d);
      check($sformatf("vec%0d CountOut", n), CountOut, {5'(vecs[n].o1), 5'(vecs[n].o0)});
    end

    // Reset mid-window discards the partial window and clears outputs.
    Mode = 2'b00;
    for (int i = 0; i < 5; i++) step(1'b1, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 2'b11, 1'b0, 1'b1);
      check("midreset DataOut", DataOut, 0);
      check("midreset DataValid", DataValid, 0);
      check("midreset CountOut", CountOut, 0);
    end
    pulses.delete();
    send_win(16, 16, 1'b0);
    check("post-reset pulses", pulses.size(), 1);
    check("post-reset DataOut", DataOut, 2'b11);
    check("post-reset CountOut", CountOut, {5'd16, 5'd16});

    // Throttled input: pulses follow the 16th accepted sample, 32 cycles apart.
    pulses.delete();
    send_win(12, 4, 1'b1);
    check("throttle w1 DataOut", DataOut, 2'b01);
    check("throttle w1 CountOut", CountOut, {5'd4, 5'd12});
    send_win(3, 13, 1'b1);
    check("throttle pulses", pulses.size(), 2);
    if (pulses.size() == 2) check("throttle spacing", pulses[1] - pulses[0], 32);
    check("throttle w2 DataOut", DataOut, 2'b10);
    check("throttle w2 CountOut", CountOut, {5'd13, 5'd3});

    // Sync with a valid sample after 7 samples restarts the window at that sample.
    pulses.delete();
    for (int i = 0; i < 7; i++) step(1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 2'b01, 1'b0, 1'b0);
    check("sync no early pulse", pulses.size(), 0);
    step(1'b1, 2'b01, 1'b0, 1'b0);
    check("sync pulse", pulses.size(), 1);
    check("sync DataOut", DataOut, 2'b01);
    check("sync CountOut", CountOut, {5'd0, 5'd16});

    // Sync on what would be the window-end edge suppresses that decision.
    pulses.delete();
    for (int i = 0; i < 15; i++) step(1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b1, 1'b0);
    check("sync@end no pulse", pulses.size(), 0);
    check("sync@end holds DataOut", DataOut, 2'b01);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 2'b10, 1'b0, 1'b0);
    check("sync@end later pulse", pulses.size(), 1);
    check("sync@end CountOut", CountOut, {5'd16, 5'd0});

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      Mode      = 2'($urandom_range(0, 3));
      Threshold = 5'($urandom_range(0, 31));
      Hyst      = 5'($urandom_range(0, 12));
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 499) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
